sillyfunction: RTL and testbench
================================

Name: sillyfunction

Overview:
- Fixed 3-input Boolean function y = ~b & (~c | a), equivalently ~a~b~c + a~b~c + a~bc.
- Provides a zero-latency combinational output, a registered copy and a saturating count of cycles where the function is true.
- Used as a small glue and qualification block in the verification exercise designs.
- One clock domain: clk, with asynchronous active-low reset rst_n.

Parameters:
- CNT_W, default 8: width of hit_cnt; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  function input, MSB of the index {a,b,c}.
- b  input  1  function input.
- c  input  1  function input, LSB of the index {a,b,c}.
- y  output  1  combinational function result, no clock involvement.
- y_q  output  1  y registered on the rising edge of clk.
- q_valid  output  1  high once y_q holds a sampled value since the last reset.
- hit_cnt  output  CNT_W  saturating count of clock edges at which y was 1.

Behaviour:
- Truth table for {a,b,c} -> y:
  - 000 -> 1, 001 -> 0, 010 -> 0, 011 -> 0
  - 100 -> 1, 101 -> 1, 110 -> 0, 111 -> 0
- y is purely combinational.
  - It settles within the same delta or time step as any input change.
  - It is independent of clk and rst_n, including while in reset.
- Any X or Z on a, b or c propagates as X on y. The block does not mask unknown inputs.
- Reset (rst_n = 0) asynchronously forces y_q = 0, q_valid = 0 and hit_cnt = 0. These values hold for as long as rst_n is low.
- On the first rising clk edge with rst_n = 1:
  - y_q <= y
  - q_valid <= 1
  - q_valid stays 1 until the next reset.
- Latency: y_q equals the y value sampled at the previous rising edge (1-cycle latency).
- hit_cnt: at each rising edge with rst_n = 1 and y = 1, increment by 1.
  - It saturates at 2^CNT_W - 1 and never wraps.
  - It holds when y = 0.
- Reset asserted mid-operation: all registered outputs clear immediately, without waiting for a clock edge. y keeps tracking its inputs.
- Reset released coincident with a clk edge: that edge is not counted. The first sample is taken on the following edge.
- Inputs changing between edges have no effect on registered state except via the value present at the edge.

Decomposition:
- No shared package is needed.
- The truth table is a local 8-bit constant 8'b0011_0001, indexed by {a,b,c}; bit0 corresponds to 000.
- Optional single sub-module sat_counter (parameter W) implementing the saturating increment. Everything else is inline.

Test Plan:
- Combinational sweep: apply all 8 {a,b,c} values, 10 ns apart, checking y each time.
  - 000 -> 1, 001 -> 0, 010 -> 0, 011 -> 0, 100 -> 1, 101 -> 1, 110 -> 0, 111 -> 0.
  - Repeat the full sweep with rst_n held at 0: y gives identical results.
- Register latency: release reset, apply 100 then 110 on consecutive edges.
  - y_q = 1 one cycle after the 100 edge, then 0.
  - q_valid rises at the first post-reset edge.
- Counting: hold 000 for 5 edges, then 011 for 3 edges -> hit_cnt = 5.
- Saturation: CNT_W = 2, hold 101 for 6 edges -> hit_cnt = 3 and it stays 3.
- Async reset mid-run: with hit_cnt = 4, drop rst_n between edges.
  - y_q, q_valid and hit_cnt go to 0 immediately, before the next edge.
  - After release and 2 edges at 100, hit_cnt = 2.

Source files
------------

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled clock edges and
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic at_max;

    assign at_max = (cnt == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sillyfunction.sv
// y = ~b & (~c | a) with a registered copy, a sample-valid
// flag and a saturating count of edges where y was true.
module sillyfunction #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic             q_valid,
    output logic [CNT_W-1:0] hit_cnt
);

    // Bit n is the result for {a,b,c} == n.
    localparam logic [7:0] TRUTH = 8'b0011_0001;

    logic [2:0] idx;

    assign idx = {a, b, c};
    assign y   = TRUTH[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            y_q     <= y;
            q_valid <= 1'b1;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_hit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (y),
        .cnt  (hit_cnt)
    );

endmodule

// File: tb/tb_sillyfunction.sv
// Scoreboard bench for sillyfunction: a default-width and a
// 2-bit-counter instance share the same stimulus.
module tb_sillyfunction;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       y8, yq8, v8;
    logic [7:0] cnt8;
    logic       y2, yq2, v2;
    logic [1:0] cnt2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       yq;
        logic       v;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];

    logic       m_yq;
    logic       m_v;
    logic [7:0] m_c8;
    logic [1:0] m_c2;

    always #5 clk = ~clk;

    sillyfunction #(.CNT_W(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y8),
        .y_q    (yq8),
        .q_valid(v8),
        .hit_cnt(cnt8)
    );

    sillyfunction #(.CNT_W(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y2),
        .y_q    (yq2),
        .q_valid(v2),
        .hit_cnt(cnt2)
    );

    function automatic logic f(input logic fa, input logic fb,
                               input logic fc);
        return ~fb & (~fc | fa);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input exp_t e);
        chk({tag, ".y_q"},    32'(yq8),  32'(e.yq));
        chk({tag, ".y_q2"},   32'(yq2),  32'(e.yq));
        chk({tag, ".valid"},  32'(v8),   32'(e.v));
        chk({tag, ".valid2"}, 32'(v2),   32'(e.v));
        chk({tag, ".cnt8"},   32'(cnt8), 32'(e.c8));
        chk({tag, ".cnt2"},   32'(cnt2), 32'(e.c2));
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.yq = m_yq;
        e.v  = m_v;
        e.c8 = m_c8;
        e.c2 = m_c2;
        return e;
    endfunction

    task automatic model_clear();
        m_yq = 1'b0;
        m_v  = 1'b0;
        m_c8 = '0;
        m_c2 = '0;
    endtask

    // Called mid-cycle; checks y, then registers after next edge.
    task automatic step(input logic [2:0] abc);
        logic ey;
        exp_t got;
        {a, b, c} = abc;
        #1;
        ey = f(abc[2], abc[1], abc[0]);
        chk($sformatf("y[%b]", abc),  32'(y8), 32'(ey));
        chk($sformatf("y2[%b]", abc), 32'(y2), 32'(ey));
        if (rst_n) begin
            m_yq = ey;
            m_v  = 1'b1;
            if (ey && m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
            if (ey && m_c2 != 2'h3)  m_c2 = m_c2 + 2'd1;
        end
        sb.push_back(model_now());
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_regs($sformatf("edge[%b]", abc), got);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_regs("rst", model_now());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #2;
        chk_regs("por", model_now());

        // Combinational sweep with reset held low.
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #1;
            chk($sformatf("rst_y[%0d]", i), 32'(y8),
                32'(f(a, b, c)));
            chk_regs("rst_hold", model_now());
            #9;
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(3'(i));
        chk("sweep_cnt", 32'(cnt8), 32'd3);

        reset_pulse();
        chk("lat_v0", 32'(v8), 32'd0);
        step(3'b100);
        step(3'b110);

        reset_pulse();
        repeat (5) step(3'b000);
        repeat (3) step(3'b011);
        chk("count5", 32'(cnt8), 32'd5);

        reset_pulse();
        repeat (6) step(3'b101);
        chk("sat3", 32'(cnt2), 32'd3);
        chk("nosat", 32'(cnt8), 32'd6);

        reset_pulse();
        repeat (4) step(3'b000);
        chk("pre_async", 32'(cnt8), 32'd4);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_regs("async", model_now());
        {a, b, c} = 3'b100;
        #1;
        chk("y_in_rst", 32'(y8), 32'd1);
        @(posedge clk);
        #1;
        chk_regs("async_hold", model_now());
        rst_n = 1'b1;
        repeat (2) step(3'b100);
        chk("post_async", 32'(cnt8), 32'd2);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
